// File: rtl/clk_div_detect_pkg.sv
// clk_div_detect_pkg: shared definitions for the divided-clock detector.
// Holds the FSM state encoding, the ERR_CODE values, the timeout and
// maximum-divisor limits, and a small range-check helper.
package clk_div_detect_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_EDGE = 3'd1,
    ST_MEASURE   = 3'd2,
    ST_CONFIRM   = 3'd3,
    ST_LOCK      = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_RANGE    = 2'b01;
  localparam logic [1:0] ERR_MISMATCH = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  localparam int TIMEOUT = 7;
  localparam int MAX_DIV = 3;

  localparam int CNT_W = 4;

  // A measured half-period is usable only if it fits the 2-bit divisor.
  function automatic logic in_range(input logic [CNT_W-1:0] m);
    return m <= CNT_W'(MAX_DIV);
  endfunction

endpackage

// File: rtl/clk_div_detect_sync.sv
// sync_edge_det: brings an asynchronous bit into the clk domain and flags
// transitions of either polarity.
//   clk        : sampling clock (rising edge)
//   rst_n      : synchronous active-low reset
//   async_in   : asynchronous input bit
//   level      : synchronized level (third stage)
//   edge_pulse : registered one-cycle pulse, high the cycle after the last
//                two stages differed
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic edge_pulse
);

  localparam int STAGES = 3;

  // [0],[1] are the metastability chain, [2] is the history stage.
  logic [STAGES-1:0] sync_q, sync_d;
  logic              edge_q, edge_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], async_in};
    edge_d = sync_q[1] ^ sync_q[2];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
    end
  end

  assign level      = sync_q[2];
  assign edge_pulse = edge_q;

endmodule

// File: rtl/clk_div_detect.sv
// clk_div_detect: recovers the divisor of a divided clock and reports
// lock / fault status.
//   clk_in   : system clock, all logic on rising edge
//   rst_n    : synchronous active-low reset
//   en       : measurement enable, low forces IDLE
//   div_clk  : divided clock under test (asynchronous)
//   divisor  : recovered divisor d (div_clk toggles every d+1 cycles),
//              meaningful while locked=1, holds last locked value otherwise
//   locked   : high while the measurement is stable
//   err      : one-cycle fault pulse
//   err_code : fault cause while err=1 (01 range, 10 mismatch, 11 timeout)
module clk_div_detect
  import clk_div_detect_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       en,
  input  logic       div_clk,
  output logic [1:0] divisor,
  output logic       locked,
  output logic       err,
  output logic [1:0] err_code
);

  logic div_edge;

  sync_edge_det u_sync (
    .clk        (clk_in),
    .rst_n      (rst_n),
    .async_in   (div_clk),
    .level      (),
    .edge_pulse (div_edge)
  );

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cand_q, cand_d;
  logic [1:0]       div_q, div_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;

  logic             timeout;
  logic             m_ok;

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    div_d    = div_q;
    locked_d = locked_q;
    err_d    = 1'b0;
    code_d   = ERR_NONE;

    // Half-period counter; on an edge cycle cnt_q is the measurement M.
    if (div_edge)                      cnt_d = '0;
    else if (cnt_q == {CNT_W{1'b1}})   cnt_d = cnt_q;
    else                               cnt_d = cnt_q + 1'b1;

    m_ok = in_range(cnt_q);
    // cnt keeps counting past TIMEOUT and WAIT_EDGE ignores it, so this
    // fires only once per stall.
    timeout = !div_edge && (cnt_q == CNT_W'(TIMEOUT));

    if (!en) begin
      state_d  = ST_IDLE;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_WAIT_EDGE;

        ST_WAIT_EDGE: if (div_edge) state_d = ST_MEASURE;

        ST_MEASURE: begin
          if (div_edge) begin
            if (m_ok) begin
              cand_d  = cnt_q[1:0];
              state_d = ST_CONFIRM;
            end else begin
              err_d  = 1'b1;
              code_d = ERR_RANGE;
            end
          end
        end

        ST_CONFIRM: begin
          if (div_edge) begin
            if (m_ok && cnt_q[1:0] == cand_q) begin
              state_d  = ST_LOCK;
              div_d    = cnt_q[1:0];
              locked_d = 1'b1;
            end else if (m_ok) begin
              cand_d = cnt_q[1:0];
            end else begin
              err_d   = 1'b1;
              code_d  = ERR_RANGE;
              state_d = ST_MEASURE;
            end
          end
        end

        ST_LOCK: begin
          if (div_edge) begin
            if (m_ok && cnt_q[1:0] == div_q) begin
              state_d = ST_LOCK;
            end else if (m_ok) begin
              err_d    = 1'b1;
              code_d   = ERR_MISMATCH;
              locked_d = 1'b0;
              cand_d   = cnt_q[1:0];
              state_d  = ST_CONFIRM;
            end else begin
              err_d    = 1'b1;
              code_d   = ERR_RANGE;
              locked_d = 1'b0;
              state_d  = ST_MEASURE;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase

      if (timeout && (state_q == ST_MEASURE || state_q == ST_CONFIRM ||
                      state_q == ST_LOCK)) begin
        err_d    = 1'b1;
        code_d   = ERR_TIMEOUT;
        locked_d = 1'b0;
        state_d  = ST_WAIT_EDGE;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cand_q   <= '0;
      div_q    <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      div_q    <= div_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  assign divisor  = div_q;
  assign locked   = locked_q;
  assign err      = err_q;
  assign err_code = code_q;

endmodule

// File: tb/tb_clk_div_detect.sv
// tb_clk_div_detect: scoreboard bench for clk_div_detect. Stimulus drives
// div_clk as square waves of chosen half-periods, enable drops and reset
// pulses; a reference model predicts the outputs after every clock edge and
// queues them; a monitor compares DUT outputs against the queue.
module tb_clk_div_detect;

  logic       clk_in = 1'b0;
  logic       rst_n  = 1'b0;
  logic       en     = 1'b0;
  logic       div_clk = 1'b0;
  logic [1:0] divisor;
  logic       locked, err;
  logic [1:0] err_code;

  clk_div_detect dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .en       (en),
    .div_clk  (div_clk),
    .divisor  (divisor),
    .locked   (locked),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int       cyc;
    bit       lk;
    bit [1:0] dv;
    bit       er;
    bit [1:0] cd;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // ---------------- reference model ----------------
  // A div_clk change between the samples taken at edges k-1 and k is acted
  // on at edge k+3. Samples at or before the most recent reset count as 0.
  bit samp[int];
  int last_rst = 0;
  int m_phase;          // 0 idle,1 waiting,2 measuring,3 confirming,4 locked
  int m_gap;            // cycles since last seen edge, capped at 15
  int m_cand, m_div;
  bit m_lk;

  function automatic bit samp_at(input int i);
    if (i <= last_rst || !samp.exists(i)) return 1'b0;
    return samp[i];
  endfunction

  task automatic model_step(input bit r, input bit e, input bit d, input int j);
    exp_t x;
    bit   ev, er;
    bit [1:0] cd;
    int   m;
    bit   ok;
    samp[j] = d;
    er = 1'b0; cd = 2'b00;
    if (!r) begin
      last_rst = j;
      m_phase = 0; m_gap = 0; m_cand = 0; m_div = 0; m_lk = 1'b0;
    end else begin
      ev = samp_at(j-3) ^ samp_at(j-4);
      m  = m_gap;
      ok = (m <= 3);
      if (!e) begin
        m_phase = 0; m_lk = 1'b0;
      end else if (m_phase == 0) begin
        m_phase = 1;
      end else if (m_phase == 1) begin
        if (ev) m_phase = 2;
      end else if (!ev && m == 7) begin
        er = 1'b1; cd = 2'b11; m_lk = 1'b0; m_phase = 1;
      end else if (ev) begin
        if (!ok) begin
          er = 1'b1; cd = 2'b01;
          if (m_phase == 4) m_lk = 1'b0;
          m_phase = 2;
        end else if (m_phase == 2) begin
          m_cand = m; m_phase = 3;
        end else if (m_phase == 3) begin
          if (m == m_cand) begin m_phase = 4; m_div = m; m_lk = 1'b1; end
          else m_cand = m;
        end else if (m != m_div) begin
          er = 1'b1; cd = 2'b10; m_lk = 1'b0; m_cand = m; m_phase = 3;
        end
      end
      m_gap = ev ? 0 : ((m_gap < 15) ? m_gap + 1 : 15);
    end
    x.cyc = j; x.lk = m_lk; x.dv = 2'(m_div); x.er = er; x.cd = cd;
    sb_q.push_back(x);
  endtask

  // ---------------- stimulus ----------------
  bit dv_lvl = 1'b0;
  int ph = 0;

  task automatic cyc_drive(input bit r, input bit e, input bit d);
    @(posedge clk_in);
    #1;
    rst_n = r; en = e; div_clk = d;
    model_step(r, e, d, cyc + 1);
  endtask

  // per = toggle interval in cycles, 0 freezes div_clk
  task automatic seg(input int per, input int n, input bit e);
    for (int i = 0; i < n; i++) begin
      if (per != 0) begin
        ph++;
        if (ph >= per) begin ph = 0; dv_lvl = ~dv_lvl; end
      end
      cyc_drive(1'b1, e, dv_lvl);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk_in);
      #3;
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        x = sb_q.pop_front();
        n_cmp++;
        if ({locked, divisor, err, err_code} !== {x.lk, x.dv, x.er, x.cd}) begin
          n_bad++;
          $display("FAIL outputs cyc=%0d: got locked=%b divisor=%0d err=%b code=%b, need locked=%b divisor=%0d err=%b code=%b",
                   cyc, locked, divisor, err, err_code, x.lk, x.dv, x.er, x.cd);
        end
      end
    end
  end

  initial begin : stim
    // reset
    repeat (3) cyc_drive(1'b0, 1'b0, 1'b0);
    // toggle every 3 -> divisor 2
    seg(3, 30, 1'b1);
    // lock at 0, then every 2 -> mismatch, relock at 1
    seg(1, 20, 1'b1);
    seg(2, 20, 1'b1);
    // lock at 3, freeze -> timeout once, resume -> relock at 3
    seg(4, 30, 1'b1);
    seg(0, 15, 1'b1);
    seg(4, 30, 1'b1);
    // toggle every 6 -> range errors, never locked
    seg(6, 40, 1'b1);
    // reset during acquisition, then full reacquisition
    seg(4, 11, 1'b1);
    cyc_drive(1'b0, 1'b1, dv_lvl);
    seg(4, 30, 1'b1);
    // drop enable while locked, then reacquire
    seg(0, 2, 1'b0);
    seg(4, 30, 1'b1);
    // boundary half-periods: 8 -> range error at M=7, 9 -> timeout
    seg(8, 30, 1'b1);
    seg(9, 30, 1'b1);
    // randomized segments
    for (int s = 0; s < 40; s++) begin
      int per, len;
      bit e;
      per = $urandom_range(0, 9);
      len = $urandom_range(8, 60);
      e   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) cyc_drive(1'b0, e, dv_lvl);
      seg(per, len, e);
    end
    repeat (3) @(posedge clk_in);
    #4;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d unchecked entries, need 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
